// File: rtl/cmd_stream_gen.sv
// cmd_stream_gen: scripted command-word generator feeding the host-to-core FIFO write port.
module cmd_stream_gen #(
  parameter int fifo_widthu = 13,
  parameter int data_width = 32,
  parameter int headroom = 4,
  parameter int count_width = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [data_width-1:0]  seed,
  input  logic [count_width-1:0] count,
  input  logic [7:0]             rounds,
  input  logic                   abort,
  input  logic [fifo_widthu:0]   fifo_usedw,
  output logic                   fifo_wren,
  output logic [data_width-1:0]  fifo_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            words_sent
);
  localparam int pw = data_width - 6;
  localparam logic [data_width-1:0] tail0_w = data_width'(1) << (data_width - 5);
  localparam logic [data_width-1:0] tail1_w = tail0_w | (data_width'(1) << (data_width - 12));
  localparam logic [data_width-1:0] go_w = data_width'(1) << (data_width - 1);
  localparam logic [fifo_widthu-1:0] lim = fifo_widthu'(2 ** fifo_widthu - headroom);
  typedef enum logic [2:0] {IDLE, HDR, BODY, TAIL0, TAIL1, GO, DONE} state_t;
  state_t state, state_n;
  logic [1:0] mode_q;
  logic [data_width-1:0] seed_q, word, incr_w;
  logic [count_width-1:0] count_q, idx;
  logic [7:0] rounds_q, rnd;
  logic space, accept, wr, last_idx, last_rnd;
  assign space = ~fifo_usedw[fifo_widthu] & (fifo_usedw[fifo_widthu-1:0] < lim);
  assign accept = (state == IDLE) & start & ~abort & (mode != 2'd3);
  assign last_idx = idx == count_q - count_width'(1);
  assign last_rnd = rnd == rounds_q - 8'd1;
  // payload arithmetic is confined to the low field so the opcode never sees a carry
  assign incr_w = {seed_q[data_width-1:pw], seed_q[pw-1:0] + pw'(idx) + pw'(mode_q == 2'd2)};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    wr = 1'b0;
    word = fifo_data;
    case (state)
      IDLE: if (accept) state_n = mode == 2'd2 ? HDR : count == '0 ? DONE : BODY;
      HDR: if (space) begin
        wr = 1'b1;
        word = seed_q;
        state_n = count_q == '0 ? TAIL0 : BODY;
      end
      BODY: if (space) begin
        wr = 1'b1;
        word = mode_q == 2'd0 ? seed_q : incr_w;
        state_n = !last_idx ? BODY : mode_q == 2'd2 ? TAIL0 : DONE;
      end
      TAIL0: if (space) begin
        wr = 1'b1;
        word = tail0_w;
        state_n = TAIL1;
      end
      TAIL1: if (space) begin
        wr = 1'b1;
        word = tail1_w;
        state_n = GO;
      end
      GO: if (space) begin
        wr = 1'b1;
        word = go_w;
        state_n = last_rnd ? DONE : HDR;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_n = IDLE;
      wr = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      fifo_wren <= 1'b0;
      fifo_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      words_sent <= '0;
      mode_q <= '0;
      seed_q <= '0;
      count_q <= '0;
      rounds_q <= '0;
      idx <= '0;
      rnd <= '0;
    end else begin
      fifo_wren <= wr;
      if (wr) fifo_data <= word;
      busy <= ~abort & (state != IDLE) & (state != DONE);
      done <= ~abort & (state == DONE);
      if (state == IDLE && start && !abort) err <= mode == 2'd3;
      words_sent <= accept ? 32'd0 : words_sent + 32'(wr);
      if (accept) begin
        mode_q <= mode;
        seed_q <= seed;
        count_q <= count;
        rounds_q <= rounds == 8'd0 ? 8'd1 : rounds;
        idx <= '0;
        rnd <= '0;
      end else if (wr) begin
        if (state == HDR) idx <= '0;
        if (state == BODY) idx <= idx + count_width'(1);
        if (state == GO) rnd <= rnd + 8'd1;
      end
    end
endmodule
